uart_hex_acc_fsm: RTL and testbench
===================================

// Module: uart_hex_acc_fsm
// PURPOSE
//  Parametrised successor of the UART hex-accumulator command FSM.
//  - Parses ASCII command lines: [op] hex-digits CR LF.
//  - Applies add, subtract or load to a wide accumulator.
//  - Replies with a ROM message (result/overflow/error) followed by the accumulator in hex, CR LF.
//  - Sits between the UART RX/TX pair, the hex<->ASCII decoders and the message ROM.
// PARAMETERS
//  OP_DIGITS   7       max operand digits (nibbles) per command
//  ACC_DIGITS  21      accumulator width in nibbles (ACC_W = 4*ACC_DIGITS)
//  ADDR_W      7       message ROM address width
//  ACC_RST_VAL all-1s  accumulator value after reset
// PORTS
//  CLK           in   1          clock, rising edge
//  RST_N         in   1          async active-low reset
//  RX_DATA_EN    in   1          1-cycle strobe: RX_DATA_R valid
//  RX_DATA_R     in   10         [9:8] error class (00 none), [7:0] byte
//  ASCII_DATA    out  8          = RX_DATA_R[7:0], to hex decoder
//  HEX_FLAG      in   1          ASCII_DATA is a hex digit
//  DC_HEX_DATA   in   4          decoded nibble
//  HEX_DATA      out  4          accumulator nibble selected by digit counter
//  DC_ASCII_DATA in   8          ASCII of HEX_DATA
//  ADDR          out  ADDR_W     message ROM address
//  DATA          in   8          ROM byte, combinational from ADDR
//  TX_RDY_T      out  1          level: response in progress, TX_DATA_T valid
//  TX_DATA_T     out  8          byte to transmitter
//  TX_RDY_R      in   1          1-cycle pulse: transmitter took TX_DATA_T
// BEHAVIOUR
//  Reset (RST_N=0, async):
//   - TX_RDY_T=0, TX_DATA_T=0, ADDR=0; accumulator=ACC_RST_VAL; counters 0; state IDLE.
//   - Applies mid-frame/mid-reply: the reply is abandoned at once.
//  States: IDLE, ROP, RLF, TLD, TMSG, TDIG, TCR, TLF.
//  IDLE, on RX_DATA_EN:
//   - '+' sets op ADD, '-' sets op SUB, '=' sets op LOAD -> ROP.
//   - A hex digit means implicit SUB: shift the digit in -> ROP.
//  ROP:
//   - Hex digit shifts into operand (left shift by 4).
//   - CR with 1..OP_DIGITS digits -> RLF.
//   - Operand shorter than OP_DIGITS is zero-extended on the left to ACC_W.
//  RLF:
//   - LF: ACC <= ACC+op / ACC-op / op; OVF <= carry-out (ADD), borrow (SUB), 0 (LOAD).
//   - ADDR <= MSG_RES_A0 (OVF=0) or MSG_OVF_A0; -> TLD.
//  Errors (any receive state):
//   - Trigger: RX_DATA_R[9:8]!=0, unexpected char, CR with 0 digits, digit OP_DIGITS+1, non-LF in RLF.
//   - ADDR/end <= error range per class (00 syntax 8..25, 01 26..43, 10 44..66, 11 67..74).
//   - Accumulator unchanged; digit print skipped; -> TLD.
//  TLD (1 cycle): TX_DATA_T<=DATA, TX_RDY_T<=1, ADDR++ -> TMSG.
//  TMSG, on each TX_RDY_R:
//   - Next ROM byte.
//   - After the end address: first digit (result reply) -> TDIG, else CR -> TCR.
//  TDIG, on each TX_RDY_R: next DC_ASCII_DATA, MS nibble first; after ACC_DIGITS digits CR -> TCR.
//  TCR, on TX_RDY_R: LF -> TLF.
//  TLF, on TX_RDY_R: TX_RDY_T<=0 -> IDLE; the reply ends.
//  Other rules:
//   - RX_DATA_EN ignored (byte dropped) while TX_RDY_T=1.
//   - Latency: LF strobe at cycle N -> TX_RDY_T=1 with first ROM byte at cycle N+2.
//   - Arithmetic is modulo 2^ACC_W.
//   - TX_RDY_R is ignored when TX_RDY_T=0.
// CONFIGURATION
//  ZERO_SUPPRESS_EN
//   - Defined: leading zero nibbles of the result are skipped without being sent; at least the LS digit is always sent.
//   - Undefined: all ACC_DIGITS digits are sent.
// STRUCTURE
//  Package uart_acc_pkg:
//   - state enum, op enum (ADD/SUB/LOAD)
//   - ASCII constants CR/LF/'+'/'-'/'='
//   - ROM ranges MSG_RES 0..7, ERR 8..74, MSG_OVF 75..82
//  Sub-module acc_alu: ACC_W add/sub/load with carry/borrow out, combinational.
// TESTING
//  1 reset; "-0000001",CR,LF -> ROM 0..7, then "FFFFFFFFFFFFFFFFFFFFE", CR, LF.
//  2 "=1",CR,LF then "-2",CR,LF -> second reply is ROM 75..82 + 21 x 'F'.
//  3 RX_DATA_R=10'h141 (class 01) in IDLE -> ROM 26..43, CR, LF; accumulator unchanged.
//  4 "+12345678",CR -> syntax error at 8th digit: ROM 8..25, CR, LF.
//  5 RST_N low during TDIG -> TX_RDY_T=0 same cycle; next query shows ACC_RST_VAL.
//  6 "=5",CR,LF -> "5" with ZERO_SUPPRESS_EN, else 20 x '0' then '5'.

Source files
------------

// File: rtl/uart_acc_pkg.sv
// Shared types and constants for the UART hex-accumulator command FSM:
// state/op enums, ASCII control characters and the message ROM address map.
package uart_acc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ROP,
    S_RLF,
    S_TLD,
    S_TMSG,
    S_TDIG,
    S_TCR,
    S_TLF
  } state_e;

  typedef enum logic [1:0] {
    OP_ADD,
    OP_SUB,
    OP_LOAD
  } op_e;

  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_LF    = 8'h0A;
  localparam logic [7:0] ASC_PLUS  = 8'h2B;
  localparam logic [7:0] ASC_MINUS = 8'h2D;
  localparam logic [7:0] ASC_EQ    = 8'h3D;

  localparam int MSG_RES_A0 = 0;
  localparam int MSG_RES_A1 = 7;
  localparam int MSG_ERR_A0 = 8;
  localparam int MSG_ERR_A1 = 74;
  localparam int MSG_OVF_A0 = 75;
  localparam int MSG_OVF_A1 = 82;

  typedef struct packed {
    logic [6:0] first;
    logic [6:0] last;
  } msg_rng_t;

  // The error block is split into one message per receive error class.
  function automatic msg_rng_t err_rng(input logic [1:0] cls);
    msg_rng_t r;
    case (cls)
      2'b00:   begin r.first = 7'd8;  r.last = 7'd25; end
      2'b01:   begin r.first = 7'd26; r.last = 7'd43; end
      2'b10:   begin r.first = 7'd44; r.last = 7'd66; end
      default: begin r.first = 7'd67; r.last = 7'd74; end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/acc_alu.sv
// Combinational accumulator ALU: add / subtract / load with carry or
// borrow out in the extra MSB of the internal sum.
module acc_alu
  import uart_acc_pkg::*;
#(
  parameter int ACC_W = 84
) (
  input  logic [ACC_W-1:0] acc_i,
  input  logic [ACC_W-1:0] opnd_i,
  input  op_e              op_i,
  output logic [ACC_W-1:0] res_o,
  output logic             ovf_o
);

  logic [ACC_W:0] sum;

  always_comb begin
    sum = {1'b0, acc_i};
    case (op_i)
      OP_ADD:  sum = {1'b0, acc_i} + {1'b0, opnd_i};
      OP_SUB:  sum = {1'b0, acc_i} - {1'b0, opnd_i};
      OP_LOAD: sum = {1'b0, opnd_i};
      default: sum = {1'b0, acc_i};
    endcase
  end

  assign res_o = sum[ACC_W-1:0];
  assign ovf_o = sum[ACC_W];

endmodule

// File: rtl/uart_hex_acc_fsm.sv
// UART hex-accumulator command FSM: parses "[op]hex CR LF", updates the
// accumulator and replies ROM message + hex result. ZERO_SUPPRESS_EN drops leading zero digits.
//
// state | meaning
// IDLE  | waiting for op char or first digit
// ROP   | collecting operand digits until CR
// RLF   | CR seen, waiting for LF to execute
// TLD   | load first ROM byte of the reply
// TMSG  | sending ROM message bytes
// TDIG  | sending accumulator digits, MS first
// TCR   | sending CR
// TLF   | sending LF, reply ends on its ack
module uart_hex_acc_fsm
  import uart_acc_pkg::*;
#(
  parameter int OP_DIGITS  = 7,
  parameter int ACC_DIGITS = 21,
  parameter int ADDR_W     = 7,
  parameter logic [4*ACC_DIGITS-1:0] ACC_RST_VAL = '1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              RX_DATA_EN,
  input  logic [9:0]        RX_DATA_R,
  output logic [7:0]        ASCII_DATA,
  input  logic              HEX_FLAG,
  input  logic [3:0]        DC_HEX_DATA,
  output logic [3:0]        HEX_DATA,
  input  logic [7:0]        DC_ASCII_DATA,
  output logic [ADDR_W-1:0] ADDR,
  input  logic [7:0]        DATA,
  output logic              TX_RDY_T,
  output logic [7:0]        TX_DATA_T,
  input  logic              TX_RDY_R
);

  localparam int ACC_W  = 4 * ACC_DIGITS;
  localparam int OPND_W = 4 * OP_DIGITS;
  localparam int CNT_W  = $clog2(OP_DIGITS + 1);
  localparam int DIG_W  = $clog2(ACC_DIGITS);

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic [OPND_W-1:0]   opnd_q, opnd_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   end_q, end_d;
  logic [DIG_W-1:0]    dig_q, dig_d;
  logic                show_q, show_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                tx_rdy_q, tx_rdy_d;

  logic [ACC_W-1:0]    alu_res;
  logic                alu_ovf;
  logic                rx_ok;
  logic [7:0]          rx_byte;
  logic [1:0]          rx_cls;
  msg_rng_t            err_r;
  logic                err;
  logic [DIG_W-1:0]    hex_sel;
  logic [DIG_W-1:0]    first_dig;

  assign ASCII_DATA = RX_DATA_R[7:0];
  assign rx_byte    = RX_DATA_R[7:0];
  assign rx_cls     = RX_DATA_R[9:8];
  assign rx_ok      = RX_DATA_EN && !tx_rdy_q;
  assign err_r      = err_rng(rx_cls);

  assign ADDR      = addr_q;
  assign TX_RDY_T  = tx_rdy_q;
  assign TX_DATA_T = tx_data_q;

  acc_alu #(
    .ACC_W (ACC_W)
  ) u_alu (
    .acc_i  (acc_q),
    .opnd_i (ACC_W'(opnd_q)),
    .op_i   (op_q),
    .res_o  (alu_res),
    .ovf_o  (alu_ovf)
  );

  // In TDIG the decoder must already present the next digit to be sent.
  always_comb begin
    hex_sel = dig_q;
    if (state_q == S_TDIG && dig_q != '0) hex_sel = dig_q - DIG_W'(1);
  end

  assign HEX_DATA = acc_q[{hex_sel, 2'b00} +: 4];

`ifdef ZERO_SUPPRESS_EN
  always_comb begin
    first_dig = '0;
    for (int i = 0; i < ACC_DIGITS; i++) begin
      if (acc_q[4*i +: 4] != 4'h0) first_dig = DIG_W'(i);
    end
  end
`else
  assign first_dig = DIG_W'(ACC_DIGITS - 1);
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= S_IDLE;
      op_q      <= OP_SUB;
      opnd_q    <= '0;
      cnt_q     <= '0;
      acc_q     <= ACC_RST_VAL;
      addr_q    <= '0;
      end_q     <= '0;
      dig_q     <= '0;
      show_q    <= 1'b0;
      tx_data_q <= '0;
      tx_rdy_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      opnd_q    <= opnd_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      addr_q    <= addr_d;
      end_q     <= end_d;
      dig_q     <= dig_d;
      show_q    <= show_d;
      tx_data_q <= tx_data_d;
      tx_rdy_q  <= tx_rdy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    opnd_d    = opnd_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    addr_d    = addr_q;
    end_d     = end_q;
    dig_d     = dig_q;
    show_d    = show_q;
    tx_data_d = tx_data_q;
    tx_rdy_d  = tx_rdy_q;
    err       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_ok) begin
          opnd_d = '0;
          cnt_d  = '0;
          if (rx_cls != 2'b00) begin
            err = 1'b1;
          end else if (rx_byte == ASC_PLUS) begin
            op_d    = OP_ADD;
            state_d = S_ROP;
          end else if (rx_byte == ASC_MINUS) begin
            op_d    = OP_SUB;
            state_d = S_ROP;
          end else if (rx_byte == ASC_EQ) begin
            op_d    = OP_LOAD;
            state_d = S_ROP;
          end else if (HEX_FLAG) begin
            op_d    = OP_SUB;
            opnd_d  = OPND_W'(DC_HEX_DATA);
            cnt_d   = CNT_W'(1);
            state_d = S_ROP;
          end else begin
            err = 1'b1;
          end
        end
      end
      S_ROP: begin
        if (rx_ok) begin
          if (rx_cls != 2'b00) begin
            err = 1'b1;
          end else if (HEX_FLAG) begin
            if (cnt_q == CNT_W'(OP_DIGITS)) begin
              err = 1'b1;
            end else begin
              opnd_d = {opnd_q[OPND_W-5:0], DC_HEX_DATA};
              cnt_d  = cnt_q + CNT_W'(1);
            end
          end else if (rx_byte == ASC_CR && cnt_q != '0) begin
            state_d = S_RLF;
          end else begin
            err = 1'b1;
          end
        end
      end
      S_RLF: begin
        if (rx_ok) begin
          if (rx_cls == 2'b00 && rx_byte == ASC_LF) begin
            acc_d   = alu_res;
            addr_d  = alu_ovf ? ADDR_W'(MSG_OVF_A0) : ADDR_W'(MSG_RES_A0);
            end_d   = alu_ovf ? ADDR_W'(MSG_OVF_A1) : ADDR_W'(MSG_RES_A1);
            show_d  = 1'b1;
            state_d = S_TLD;
          end else begin
            err = 1'b1;
          end
        end
      end
      S_TLD: begin
        tx_data_d = DATA;
        tx_rdy_d  = 1'b1;
        addr_d    = addr_q + ADDR_W'(1);
        dig_d     = first_dig;
        state_d   = S_TMSG;
      end
      S_TMSG: begin
        if (TX_RDY_R) begin
          if (addr_q == end_q + ADDR_W'(1)) begin
            if (show_q) begin
              tx_data_d = DC_ASCII_DATA;
              state_d   = S_TDIG;
            end else begin
              tx_data_d = ASC_CR;
              state_d   = S_TCR;
            end
          end else begin
            tx_data_d = DATA;
            addr_d    = addr_q + ADDR_W'(1);
          end
        end
      end
      S_TDIG: begin
        if (TX_RDY_R) begin
          if (dig_q == '0) begin
            tx_data_d = ASC_CR;
            state_d   = S_TCR;
          end else begin
            tx_data_d = DC_ASCII_DATA;
            dig_d     = dig_q - DIG_W'(1);
          end
        end
      end
      S_TCR: begin
        if (TX_RDY_R) begin
          tx_data_d = ASC_LF;
          state_d   = S_TLF;
        end
      end
      S_TLF: begin
        if (TX_RDY_R) begin
          tx_rdy_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Any receive error replaces the pending command with an error reply.
    if (err) begin
      addr_d  = ADDR_W'(err_r.first);
      end_d   = ADDR_W'(err_r.last);
      show_d  = 1'b0;
      state_d = S_TLD;
    end
  end

endmodule

// File: tb/tb_uart_hex_acc_fsm.sv
// Bench for uart_hex_acc_fsm: directed command lines plus random lines checked
// against a string-level command model. Honours ZERO_SUPPRESS_EN like the design.
module tb_uart_hex_acc_fsm;

  localparam int ACC_DIGITS = 21;
  localparam int OP_DIGITS  = 7;
  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       RX_DATA_EN;
  logic [9:0] RX_DATA_R;
  logic [7:0] ASCII_DATA;
  logic       HEX_FLAG;
  logic [3:0] DC_HEX_DATA;
  logic [3:0] HEX_DATA;
  logic [7:0] DC_ASCII_DATA;
  logic [6:0] ADDR;
  logic [7:0] DATA;
  logic       TX_RDY_T;
  logic [7:0] TX_DATA_T;
  logic       TX_RDY_R;

  int checks = 0;
  int errors = 0;
  logic [83:0] m_acc;
  logic [7:0]  exp_q[$];

  always #5 CLK = ~CLK;

  function automatic logic [7:0] rom_byte(input logic [6:0] a);
    return 8'(a) * 8'd5 + 8'h21;
  endfunction

  function automatic bit is_hex(input logic [7:0] c);
    return (c >= "0" && c <= "9") || (c >= "A" && c <= "F") || (c >= "a" && c <= "f");
  endfunction

  function automatic logic [3:0] hex_val(input logic [7:0] c);
    if (c >= "0" && c <= "9") return 4'(c - 8'h30);
    if (c >= "A" && c <= "F") return 4'(c - 8'h37);
    if (c >= "a" && c <= "f") return 4'(c - 8'h57);
    return 4'h0;
  endfunction

  function automatic logic [7:0] asc(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + 8'(n) : 8'h37 + 8'(n);
  endfunction

  assign DATA          = rom_byte(ADDR);
  assign HEX_FLAG      = is_hex(ASCII_DATA);
  assign DC_HEX_DATA   = hex_val(ASCII_DATA);
  assign DC_ASCII_DATA = asc(HEX_DATA);

  uart_hex_acc_fsm dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .RX_DATA_EN    (RX_DATA_EN),
    .RX_DATA_R     (RX_DATA_R),
    .ASCII_DATA    (ASCII_DATA),
    .HEX_FLAG      (HEX_FLAG),
    .DC_HEX_DATA   (DC_HEX_DATA),
    .HEX_DATA      (HEX_DATA),
    .DC_ASCII_DATA (DC_ASCII_DATA),
    .ADDR          (ADDR),
    .DATA          (DATA),
    .TX_RDY_T      (TX_RDY_T),
    .TX_DATA_T     (TX_DATA_T),
    .TX_RDY_R      (TX_RDY_R)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [9:0] b);
    @(negedge CLK);
    RX_DATA_EN = 1'b1;
    RX_DATA_R  = b;
    @(negedge CLK);
    RX_DATA_EN = 1'b0;
    RX_DATA_R  = '0;
  endtask

  task automatic make_reply(input int first, input int last, input bit digits);
    bit started;
    exp_q.delete();
    for (int a = first; a <= last; a++) exp_q.push_back(rom_byte(7'(a)));
    if (digits) begin
      started = 1'b0;
      for (int i = ACC_DIGITS - 1; i >= 0; i--) begin
`ifdef ZERO_SUPPRESS_EN
        if (m_acc[4*i +: 4] != 4'h0 || i == 0) started = 1'b1;
`else
        started = 1'b1;
`endif
        if (started) exp_q.push_back(asc(m_acc[4*i +: 4]));
      end
    end
    exp_q.push_back(CR);
    exp_q.push_back(LF);
  endtask

  // Consume the reply, acknowledging each byte after a random gap filled with
  // RX strobes that must be dropped. Returns early after byte index abort_at.
  task automatic collect(input int abort_at);
    int w = 0;
    while (TX_RDY_T !== 1'b1 && w < 10) begin
      @(negedge CLK);
      w++;
    end
    chk("reply_latency", w, 1);
    if (w >= 10) return;
    for (int k = 0; k < exp_q.size(); k++) begin
      chk($sformatf("tx_rdy_byte%0d", k), TX_RDY_T, 1);
      chk($sformatf("tx_data_byte%0d", k), TX_DATA_T, exp_q[k]);
      if (k == abort_at) return;
      repeat ($urandom_range(0, 2)) begin
        RX_DATA_EN = 1'($urandom_range(0, 1));
        RX_DATA_R  = 10'($urandom);
        @(negedge CLK);
      end
      RX_DATA_EN = 1'b0;
      TX_RDY_R   = 1'b1;
      @(negedge CLK);
      TX_RDY_R   = 1'b0;
    end
    chk("tx_rdy_after_lf", TX_RDY_T, 0);
  endtask

  // Scan a command line with the textual rules, send it up to the point the
  // design will react, predict the reply and check it.
  task automatic line(input string s, input logic [1:0] cls, input int abort_at);
    int idx = 0, n = 0, errpos = -1, p, last;
    int op = 1;  // 0 add, 1 sub, 2 load
    logic [83:0] v = '0;
    logic [84:0] t;
    bit ovf = 1'b0;
    if (cls != 2'b00) errpos = 0;
    else begin
      if (s[0] == 8'h2B) begin op = 0; idx = 1; end
      else if (s[0] == 8'h2D) begin op = 1; idx = 1; end
      else if (s[0] == 8'h3D) begin op = 2; idx = 1; end
      else if (!is_hex(s[0])) errpos = 0;
      if (errpos < 0) begin
        while (idx + n < s.len() && is_hex(s[idx + n])) begin
          if (n == OP_DIGITS) begin errpos = idx + n; break; end
          v = {v[79:0], hex_val(s[idx + n])};
          n++;
        end
        if (errpos < 0) begin
          p = idx + n;
          if (s[p] != CR || n == 0) errpos = p;
          else if (s[p + 1] != LF) errpos = p + 1;
        end
      end
    end
    last = (errpos < 0) ? s.len() - 1 : errpos;
    for (int i = 0; i <= last; i++) send({(i == 0) ? cls : 2'b00, s[i]});
    if (errpos < 0) begin
      case (op)
        0: begin t = {1'b0, m_acc} + {1'b0, v}; ovf = t[84]; m_acc = t[83:0]; end
        1: begin ovf = (v > m_acc); m_acc = m_acc - v; end
        default: begin ovf = 1'b0; m_acc = v; end
      endcase
      make_reply(ovf ? 75 : 0, ovf ? 82 : 7, 1'b1);
    end else begin
      case (cls)
        2'b00: make_reply(8, 25, 1'b0);
        2'b01: make_reply(26, 43, 1'b0);
        2'b10: make_reply(44, 66, 1'b0);
        default: make_reply(67, 74, 1'b0);
      endcase
    end
    collect(abort_at);
    if (abort_at < 0) begin
      TX_RDY_R = 1'b1;
      @(negedge CLK);
      TX_RDY_R = 1'b0;
      @(negedge CLK);
      chk("idle_ack_ignored", TX_RDY_T, 0);
    end
  endtask

  function automatic string rand_digits(input int n);
    string s = "";
    logic [3:0] d;
    for (int i = 0; i < n; i++) begin
      d = 4'($urandom_range(0, 15));
      s = $sformatf("%s%c", s, ($urandom_range(0, 3) == 0 && d > 9) ? asc(d) + 8'h20 : asc(d));
    end
    return s;
  endfunction

  function automatic string rand_op();
    case ($urandom_range(0, 3))
      0: return "+";
      1: return "-";
      2: return "=";
      default: return "";
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    string s, ops;
    int kind;
    RST_N = 1'b0; RX_DATA_EN = 1'b0; RX_DATA_R = '0; TX_RDY_R = 1'b0;
    m_acc = '1;
    repeat (3) @(negedge CLK);
    chk("rst_tx_rdy", TX_RDY_T, 0);
    chk("rst_tx_data", TX_DATA_T, 0);
    chk("rst_addr", ADDR, 0);
    RST_N = 1'b1;
    @(negedge CLK);

    line("-0000001\r\n", 2'b00, -1);
    line("=1\r\n", 2'b00, -1);
    line("-2\r\n", 2'b00, -1);
    line("A", 2'b01, -1);
    line("+0\r\n", 2'b00, -1);
    line("+12345678\r\n", 2'b00, -1);
    line("=5\r\n", 2'b00, -1);

    // Abort a reply while digits are being sent.
    line("=0ABC\r\n", 2'b00, 10);
    #2 RST_N = 1'b0;
    #1;
    chk("midreply_rst_tx_rdy", TX_RDY_T, 0);
    chk("midreply_rst_tx_data", TX_DATA_T, 0);
    chk("midreply_rst_addr", ADDR, 0);
    m_acc = '1;
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    line("+0\r\n", 2'b00, -1);

    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 9);
      ops  = rand_op();
      case (kind)
        0, 1, 2, 3: s = {ops, rand_digits($urandom_range(1, 7)), "\r\n"};
        4: s = {ops, rand_digits($urandom_range(8, 9)), "\r\n"};
        5: s = {(ops == "") ? "+" : ops, "\r\n"};
        6: s = {ops, rand_digits($urandom_range(1, 7)), "Z\r\n"};
        7: s = {ops, rand_digits($urandom_range(1, 7)), "\rQ"};
        8: s = {rand_digits(1), "\r\n"};
        default: s = ($urandom_range(0, 1) == 1) ? "G1\r\n" : "\r\n";
      endcase
      line(s, (kind == 8) ? 2'($urandom_range(1, 3)) : 2'b00, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
